// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU memory controller and load scoreboard.
// Pure declarations: no logic, no latency, no flow control.
package fir_xifu_pkg;

    localparam int unsigned FIR_XIFU_NREGS = 32;
    localparam int unsigned FIR_XIFU_RW    = $clog2(FIR_XIFU_NREGS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READY = 2'd1,
        FULL       = 2'd2
    } fir_xifu_memctrl_state_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_load;
        logic [FIR_XIFU_RW-1:0] rd;
    } fir_xifu_idtab_entry_t;

endpackage

// File: rtl/fir_xifu_scoreboard.sv
// XIF id table, load-pending vector and ID read-after-load hazard compare; state updates one edge after accept/result.
// No backpressure of its own: hazard is combinational and folded into the controller's stall.
module fir_xifu_scoreboard
    import fir_xifu_pkg::*;
#(
    parameter  int ID_WIDTH = 4,
    parameter  int NREGS    = FIR_XIFU_NREGS,
    localparam int RW       = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                acc_vld,
    input  logic                acc_is_load,
    input  logic [ID_WIDTH-1:0] acc_id,
    input  logic [RW-1:0]       acc_rd,
    input  logic                res_vld,
    input  logic [ID_WIDTH-1:0] res_id,
    input  logic                cnt_nz,
    output logic                res_hit,
    input  logic [2:0]          id_use,
    input  logic [3*RW-1:0]     id_rs,
    input  logic                ex_load_wait,
    input  logic [RW-1:0]       ex_rd,
    output logic                hazard,
    output logic [NREGS-1:0]    pending
);

    fir_xifu_idtab_entry_t id_table [2**ID_WIDTH];
    fir_xifu_idtab_entry_t res_ent;

    assign res_ent = id_table[res_id];
    assign res_hit = res_vld & res_ent.valid & cnt_nz;

    // Accept is written after the result release so a same-rd set overrides the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2**ID_WIDTH; i++) begin
                id_table[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (res_hit) begin
                id_table[res_id].valid <= 1'b0;
                if (res_ent.is_load) begin
                    pending[RW'(res_ent.rd)] <= 1'b0;
                end
            end
            if (acc_vld) begin
                id_table[acc_id] <= '{valid: 1'b1, is_load: acc_is_load, rd: FIR_XIFU_RW'(acc_rd)};
                if (acc_is_load) begin
                    pending[acc_rd] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [RW-1:0] rs;
        hazard = 1'b0;
        rs     = '0;
        for (int k = 0; k < 3; k++) begin
            rs = id_rs[k*RW +: RW];
            if (id_use[k] && (pending[rs] || (ex_load_wait && rs == ex_rd))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_xifu_mem_ctrl.sv
// Gates EX XIF memory requests on mem_ready and an outstanding limit; zero-wait accept in the request cycle.
// Backpressure: stall_o freezes ID/EX while a request is unaccepted or ID reads a register awaiting load data.
module fir_xifu_mem_ctrl
    import fir_xifu_pkg::*;
#(
    parameter  int ID_WIDTH        = 4,
    parameter  int MAX_OUTSTANDING = 2,
    parameter  int NREGS           = FIR_XIFU_NREGS,
    localparam int RW              = $clog2(NREGS),
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                ex_mem_req_i,
    input  logic                ex_we_i,
    input  logic [RW-1:0]       ex_rd_i,
    input  logic [ID_WIDTH-1:0] ex_id_i,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    input  logic                mem_result_valid_i,
    input  logic [ID_WIDTH-1:0] mem_result_id_i,
    input  logic [2:0]          id_use_i,
    input  logic [3*RW-1:0]     id_rs_i,
    output logic                stall_o,
    output logic [CW-1:0]       outstanding_o,
    output logic [NREGS-1:0]    pending_o,
    output logic                err_o
);

    fir_xifu_memctrl_state_t state;
    logic [CW-1:0]           count;
    logic                    cnt_lt_max;
    logic                    accept;
    logic                    res_hit;
    logic                    ex_load_wait;
    logic                    hazard;

    assign cnt_lt_max = count < CW'(MAX_OUTSTANDING);

    // Once valid is raised in WAIT_READY it stays up until the handshake completes.
    always_comb begin
        mem_valid_o = 1'b0;
        unique case (state)
            IDLE:       mem_valid_o = ex_mem_req_i & cnt_lt_max;
            WAIT_READY: mem_valid_o = 1'b1;
            FULL:       mem_valid_o = 1'b0;
            default:    mem_valid_o = 1'b0;
        endcase
    end

    assign accept        = mem_valid_o & mem_ready_i;
    assign ex_load_wait  = ex_mem_req_i & ~ex_we_i & ~accept;
    assign stall_o       = (ex_mem_req_i & ~accept) | hazard;
    assign outstanding_o = count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            count <= '0;
            err_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!clear_i && ex_mem_req_i) begin
                        if (!cnt_lt_max) begin
                            state <= FULL;
                        end else if (!mem_ready_i) begin
                            state <= WAIT_READY;
                        end
                    end
                end
                WAIT_READY: begin
                    if (mem_ready_i) begin
                        state <= IDLE;
                    end
                end
                FULL: begin
                    // A returning result frees a slot, so the request can go out next cycle.
                    if (clear_i || cnt_lt_max || res_hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            unique case ({accept, res_hit})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (mem_result_valid_i && !res_hit) begin
                err_o <= 1'b1;
            end
        end
    end

    fir_xifu_scoreboard #(
        .ID_WIDTH (ID_WIDTH),
        .NREGS    (NREGS)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .acc_vld      (accept),
        .acc_is_load  (~ex_we_i),
        .acc_id       (ex_id_i),
        .acc_rd       (ex_rd_i),
        .res_vld      (mem_result_valid_i),
        .res_id       (mem_result_id_i),
        .cnt_nz       (count != '0),
        .res_hit      (res_hit),
        .id_use       (id_use_i),
        .id_rs        (id_rs_i),
        .ex_load_wait (ex_load_wait),
        .ex_rd        (ex_rd_i),
        .hazard       (hazard),
        .pending      (pending_o)
    );

endmodule

// File: tb/tb_fir_xifu_mem_ctrl.sv
// Directed bench for fir_xifu_mem_ctrl with a transaction-level reference model checked every cycle.
module tb_fir_xifu_mem_ctrl;

    localparam int MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        ex_mem_req_i;
    logic        ex_we_i;
    logic [4:0]  ex_rd_i;
    logic [3:0]  ex_id_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic        mem_result_valid_i;
    logic [3:0]  mem_result_id_i;
    logic [2:0]  id_use_i;
    logic [14:0] id_rs_i;
    logic        stall_o;
    logic [1:0]  outstanding_o;
    logic [31:0] pending_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    fir_xifu_mem_ctrl dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .clear_i            (clear_i),
        .ex_mem_req_i       (ex_mem_req_i),
        .ex_we_i            (ex_we_i),
        .ex_rd_i            (ex_rd_i),
        .ex_id_i            (ex_id_i),
        .mem_valid_o        (mem_valid_o),
        .mem_ready_i        (mem_ready_i),
        .mem_result_valid_i (mem_result_valid_i),
        .mem_result_id_i    (mem_result_id_i),
        .id_use_i           (id_use_i),
        .id_rs_i            (id_rs_i),
        .stall_o            (stall_o),
        .outstanding_o      (outstanding_o),
        .pending_o          (pending_o),
        .err_o              (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request either has valid latched (sticky) or was
    // turned away for lack of a slot (blocked); otherwise it is fresh.
    bit          m_sticky, m_blocked, m_err;
    int          m_cnt;
    bit          m_ev [16];
    bit          m_el [16];
    int          m_erd [16];
    bit [31:0]   m_pend;
    logic        e_valid, e_acc, e_hit, e_stall;

    always_comb begin
        e_valid = 1'b0;
        if (m_sticky)       e_valid = 1'b1;
        else if (m_blocked) e_valid = 1'b0;
        else                e_valid = ex_mem_req_i && (m_cnt < MAXO);
        e_acc   = e_valid && mem_ready_i;
        e_hit   = mem_result_valid_i && m_ev[mem_result_id_i] && (m_cnt != 0);
        e_stall = ex_mem_req_i && !e_acc;
        for (int k = 0; k < 3; k++) begin
            if (id_use_i[k]) begin
                if (m_pend[id_rs_i[k*5 +: 5]]) e_stall = 1'b1;
                if (ex_mem_req_i && !ex_we_i && !e_acc && id_rs_i[k*5 +: 5] == ex_rd_i) e_stall = 1'b1;
            end
        end
    end

    always @(posedge clk_i or negedge rst_ni) begin
        bit acc, hit, v, nsticky, nblocked;
        int rid;
        if (!rst_ni) begin
            m_sticky = 0; m_blocked = 0; m_err = 0; m_cnt = 0; m_pend = '0;
            for (int i = 0; i < 16; i++) begin
                m_ev[i] = 0; m_el[i] = 0; m_erd[i] = 0;
            end
        end else begin
            acc = e_acc; hit = e_hit; v = e_valid; rid = int'(mem_result_id_i);
            nsticky  = v && !mem_ready_i && (m_sticky || !clear_i);
            nblocked = !clear_i && m_cnt >= MAXO &&
                       ((m_blocked && !hit) || (!m_sticky && !m_blocked && ex_mem_req_i));
            if (mem_result_valid_i && !hit) m_err = 1;
            if (hit) begin
                m_ev[rid] = 0;
                if (m_el[rid]) m_pend[m_erd[rid]] = 0;
            end
            if (acc) begin
                m_ev[ex_id_i]  = 1;
                m_el[ex_id_i]  = !ex_we_i;
                m_erd[ex_id_i] = int'(ex_rd_i);
                if (!ex_we_i) m_pend[ex_rd_i] = 1;
            end
            m_cnt     = m_cnt + int'(acc) - int'(hit);
            m_sticky  = nsticky;
            m_blocked = nblocked;
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("mdl_mem_valid", 32'(mem_valid_o), 32'(e_valid));
            check("mdl_stall", 32'(stall_o), 32'(e_stall));
            check("mdl_outstanding", 32'(outstanding_o), 32'(m_cnt));
            check("mdl_pending", pending_o, m_pend);
            check("mdl_err", 32'(err_o), 32'(m_err));
        end
    end

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic r, input logic we, input logic [4:0] rd, input logic [3:0] id);
        ex_mem_req_i = r; ex_we_i = we; ex_rd_i = rd; ex_id_i = id;
    endtask

    task automatic res(input logic v, input logic [3:0] id);
        mem_result_valid_i = v; mem_result_id_i = id;
    endtask

    task automatic use_rs(input logic [2:0] u, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3);
        id_use_i = u; id_rs_i = {r3, r2, r1};
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; mem_ready_i = 1'b0;
        req(0, 0, 0, 0); res(0, 0); use_rs(0, 0, 0, 0);
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_mem_valid", 32'(mem_valid_o), 0);
        check("rst_stall", 32'(stall_o), 0);
        check("rst_outstanding", 32'(outstanding_o), 0);
        check("rst_pending", pending_o, 0);
        check("rst_err", 32'(err_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step;

        // Zero-wait load rd=5 id=3, then its result
        req(1, 0, 5, 3); mem_ready_i = 1; #1;
        check("s1_valid", 32'(mem_valid_o), 1);
        check("s1_stall", 32'(stall_o), 0);
        step; req(0, 0, 0, 0);
        check("s1_pend5", 32'(pending_o[5]), 1);
        check("s1_cnt", 32'(outstanding_o), 1);
        res(1, 3); step; res(0, 0);
        check("s1_pend5_clr", 32'(pending_o[5]), 0);
        check("s1_cnt0", 32'(outstanding_o), 0);

        // Three cycles without ready, accepted on the fourth
        mem_ready_i = 0; req(1, 0, 6, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("s2_wait_valid", 32'(mem_valid_o), 1);
            check("s2_wait_stall", 32'(stall_o), 1);
            step;
        end
        mem_ready_i = 1; #1;
        check("s2_acc_valid", 32'(mem_valid_o), 1);
        check("s2_acc_stall", 32'(stall_o), 0);
        step; req(0, 0, 0, 0);
        check("s2_cnt", 32'(outstanding_o), 1);
        res(1, 0); step; res(0, 0);

        // Fill to the limit, third request blocked until a result frees a slot
        req(1, 0, 10, 1); step;
        req(1, 0, 11, 2); step;
        check("s3_cnt_full", 32'(outstanding_o), 2);
        req(1, 0, 12, 4); #1;
        check("s3_blk_valid", 32'(mem_valid_o), 0);
        check("s3_blk_stall", 32'(stall_o), 1);
        step; #1;
        check("s3_full_valid", 32'(mem_valid_o), 0);
        res(1, 1); #1;
        check("s3_res_valid", 32'(mem_valid_o), 0);
        check("s3_res_stall", 32'(stall_o), 1);
        step; res(0, 0); #1;
        check("s3_issue_valid", 32'(mem_valid_o), 1);
        check("s3_issue_stall", 32'(stall_o), 0);
        step; req(0, 0, 0, 0);
        check("s3_cnt_after", 32'(outstanding_o), 2);
        res(1, 2); step; res(1, 4); step; res(0, 0);
        check("s3_cnt_drain", 32'(outstanding_o), 0);

        // Read-after-load hazard on rs2
        req(1, 0, 7, 5); step; req(0, 0, 0, 0);
        use_rs(3'b010, 0, 7, 0); #1;
        check("s4_haz", 32'(stall_o), 1);
        step;
        check("s4_haz_hold", 32'(stall_o), 1);
        use_rs(3'b010, 0, 6, 0); #1;
        check("s4_nohaz", 32'(stall_o), 0);
        use_rs(3'b010, 0, 7, 0); res(1, 5); #1;
        check("s4_haz_res", 32'(stall_o), 1);
        step; res(0, 0); #1;
        check("s4_release", 32'(stall_o), 0);
        use_rs(0, 0, 0, 0);

        // Accept and result in the same cycle on the same rd
        req(1, 0, 9, 2); step;
        check("s5_cnt1", 32'(outstanding_o), 1);
        req(1, 0, 9, 4); res(1, 2); step; req(0, 0, 0, 0); res(0, 0);
        check("s5_cnt_same", 32'(outstanding_o), 1);
        check("s5_pend9", 32'(pending_o[9]), 1);
        res(1, 4); step; res(0, 0);
        check("s5_pend9_clr", 32'(pending_o[9]), 0);

        // Result for an id never issued: sticky error
        check("s6_err0", 32'(err_o), 0);
        res(1, 5); step; res(0, 0);
        check("s6_err", 32'(err_o), 1);
        step; step;
        check("s6_err_sticky", 32'(err_o), 1);

        // Flush while waiting for ready keeps valid up
        mem_ready_i = 0; req(1, 1, 0, 6); step;
        clear_i = 1; #1;
        check("s6_clr_valid0", 32'(mem_valid_o), 1);
        step; #1;
        check("s6_clr_valid1", 32'(mem_valid_o), 1);
        mem_ready_i = 1; #1;
        check("s6_clr_stall", 32'(stall_o), 0);
        step; clear_i = 0; req(0, 0, 0, 0);
        check("s6_store_cnt", 32'(outstanding_o), 1);
        check("s6_store_pend", pending_o, 0);
        res(1, 6); step; res(0, 0);

        // Reset mid-transaction, stale result afterwards
        req(1, 0, 3, 7); step; req(0, 0, 0, 0);
        check("s7_cnt", 32'(outstanding_o), 1);
        rst_ni = 0; #1;
        check("s7_rst_cnt", 32'(outstanding_o), 0);
        check("s7_rst_pend", pending_o, 0);
        check("s7_rst_err", 32'(err_o), 0);
        @(negedge clk_i);
        rst_ni = 1;
        step;
        res(1, 7); step; res(0, 0);
        check("s7_stale_err", 32'(err_o), 1);
        check("s7_stale_cnt", 32'(outstanding_o), 0);

        step; step;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_xifu_mem_ctrl.md
# fir_xifu_mem_ctrl

Memory-transaction controller and load scoreboard for the FIR XIFU pipeline. Sits beside the EX stage: gates EX's XIF memory requests against `mem_ready` and an outstanding-transaction limit, and tracks which XIFU registers await load data. From that state it produces one stall that freezes ID/EX on memory back-pressure or read-after-load hazards.

## Interface
- `ID_WIDTH`, 4: XIF transaction id width
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unanswered transactions (1..2**ID_WIDTH)
- `NREGS`, 32: XIFU register-file entries; `RW = $clog2(NREGS)`
- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous active-low reset
- `clear_i` in 1: synchronous pipeline flush
- `ex_mem_req_i` in 1: EX holds `xfirlw`/`xfirsw`
- `ex_we_i` in 1: EX request is a store
- `ex_rd_i` in RW: load destination register
- `ex_id_i` in ID_WIDTH: XIF id of EX instruction
- `mem_valid_o` out 1: gated XIF `mem_valid`
- `mem_ready_i` in 1: XIF `mem_ready`
- `mem_result_valid_i` in 1: XIF `mem_result_valid`
- `mem_result_id_i` in ID_WIDTH: XIF `mem_result.id`
- `id_use_i` in 3: ID stage reads rs1/rs2/rs3 (bit 0/1/2)
- `id_rs_i` in 3×RW: ID source indices
- `stall_o` out 1: freeze ID and EX registers
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): accepted, unanswered count
- `pending_o` out NREGS: scoreboard bits
- `err_o` out 1: sticky protocol error

## Operation
- FSM `IDLE`, `WAIT_READY`, `FULL`; reset → `IDLE`.
- `IDLE`: on `ex_mem_req_i` with count < MAX: `mem_valid_o`=1. If `mem_ready_i`: accepted, stay `IDLE`; else → `WAIT_READY`. On `ex_mem_req_i` with count == MAX: `mem_valid_o`=0, → `FULL`.
- `WAIT_READY`: `mem_valid_o`=1 unconditionally (XIF valid never retracted); → `IDLE` on `mem_ready_i`.
- `FULL`: `mem_valid_o`=0; when count < MAX (a result arrives), → `IDLE`. The next cycle issues the request.
- Accept (`mem_valid_o & mem_ready_i`): count+1; `id_table[ex_id_i]` ← {valid=1, is_load=!ex_we_i, rd}; if load, `pending[rd]`←1.
- Result: look up `id_table[mem_result_id_i]`. If valid: count−1, entry invalidated, `pending[rd]`←0 if load. If invalid entry or count==0: `err_o`←1, count unchanged.
- Same-cycle accept and result: count unchanged. Same-rd set and clear: set wins.
- `stall_o` = (`ex_mem_req_i` & !accept) | hazard. Hazard: any `id_use_i[k]` with `pending[id_rs_i[k]]` set, or equal to `ex_rd_i` while EX holds an unaccepted load.
- `clear_i` forces `IDLE` next cycle, with one exception: in `WAIT_READY`, the state is held until ready, then → `IDLE`. `clear_i` does not touch count, id table or scoreboard, because in-flight results still return.

## Timing
- `mem_valid_o` and `stall_o` are combinational from inputs and registered state. Zero-wait acceptance takes 1 cycle with no stall.
- Count, scoreboard, id table and `err_o` update on the clock edge after the event. A result at cycle N releases a dependent ID stall at N+1.
- Reset values: FSM `IDLE`, count 0, `pending_o` 0, id table invalid, `err_o` 0, `mem_valid_o` 0, `stall_o` 0 (inputs low).
- Reset mid-transaction drops everything asynchronously. Later results for pre-reset ids set `err_o`.

## Structure
- `fir_xifu_pkg` gains `fir_xifu_memctrl_state_t` (3-state enum) and `fir_xifu_idtab_entry_t` {valid, is_load, rd}.
- Sub-module `fir_xifu_scoreboard` holds the id table, pending vector and hazard compare. `fir_xifu_mem_ctrl` keeps the FSM and counter.

## Test plan
- Load rd=5, id=3, `mem_ready` high → `mem_valid_o` 1 one cycle, no stall, `pending_o[5]`=1, count=1; result id=3 → `pending_o[5]`=0, count=0.
- `mem_ready` low 3 cycles → `mem_valid_o` and `stall_o` high 3 cycles. On the 4th cycle, ready → accepted, stall drops.
- Two loads accepted (ids 1,2), third request → `FULL`, `mem_valid_o` 0, stall. Result id 1 → next cycle request issues.
- Load rd=7 outstanding, ID reads rs2=7 → `stall_o` 1 until cycle after result; rs2=6 → no stall.
- Same-cycle accept id 4 rd=9 and result id 2 rd=9 → count unchanged, `pending_o[9]`=1.
- Result id 5 never issued → `err_o` 1 and stays; `clear_i` in `WAIT_READY` keeps `mem_valid_o` high until ready.
